// File: rtl/quadrature_lo_pkg.sv
// Shared types and helpers for the quadrature LO generator.
// QLO_DUTY25_EN selects the one-hot (1/N duty) phase decode instead of the 50% overlapping decode.
package quadrature_lo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    function automatic int ph_w(input int num_phases);
        return $clog2(num_phases);
    endfunction

    // Level of LO phase k while the ring sits at state p (num_phases is a power of two).
    function automatic logic phase_bit(input int p, input int k, input int num_phases);
`ifdef QLO_DUTY25_EN
        return (p == k);
`else
        return (((p - k) & (num_phases - 1)) < (num_phases / 2));
`endif
    endfunction

endpackage

// File: rtl/quadrature_lo_gen_if.sv
// Control/status bundle between the LO generator and its controller.
interface quadrature_lo_gen_if #(
    parameter int DIV_W      = 8,
    parameter int NUM_PHASES = 4
);
    logic                  en;
    logic                  cfg_load;
    logic [DIV_W-1:0]      div_ratio;
    logic                  dir;
    logic [NUM_PHASES-1:0] out_ph;
    logic                  lo_sync;
    logic                  busy;
    logic                  cfg_pending;

    modport master (
        output en, cfg_load, div_ratio, dir,
        input  out_ph, lo_sync, busy, cfg_pending
    );

    modport slave (
        input  en, cfg_load, div_ratio, dir,
        output out_ph, lo_sync, busy, cfg_pending
    );
endinterface

// File: rtl/quadrature_lo_gen_prescaler.sv
// Prescale counter producing the phase-advance tick, with pending/active ratio handover.
module lo_prescaler #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             running,
    input  logic             cfg_load,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             tick,
    output logic             apply,
    output logic             cfg_pending
);
    localparam logic [DIV_W-1:0] DIV_DEF = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [DIV_W-1:0] act_div_reg, act_div_next;
    logic [DIV_W-1:0] pend_div_reg, pend_div_next;
    logic             pend_reg, pend_next;
    logic             load_direct;

    always_comb begin
        tick          = running && (cnt_reg == act_div_reg);
        // While idle a load goes straight to the active ratio so a start in the same cycle uses it.
        load_direct   = !running && cfg_load;
        apply         = running ? (pend_reg && tick) : (cfg_load || pend_reg);
        act_div_next  = act_div_reg;
        if (load_direct)
            act_div_next = div_ratio;
        else if (apply)
            act_div_next = pend_div_reg;
        pend_div_next = cfg_load ? div_ratio : pend_div_reg;
        pend_next     = pend_reg;
        if (cfg_load && running)
            pend_next = 1'b1;
        else if (apply)
            pend_next = 1'b0;
        cnt_next      = (!running || tick) ? '0 : cnt_reg + DIV_ONE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_reg      <= '0;
            act_div_reg  <= DIV_DEF;
            pend_div_reg <= DIV_DEF;
            pend_reg     <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            act_div_reg  <= act_div_next;
            pend_div_reg <= pend_div_next;
            pend_reg     <= pend_next;
        end
    end

    assign cfg_pending = pend_reg;

endmodule

// File: rtl/quadrature_lo_gen.sv
// Multiphase LO generator: run/stop FSM, phase ring with sideband select and registered decode.
// Build option QLO_DUTY25_EN switches the decode to one-hot non-overlapping phases.
module quadrature_lo_gen
    import quadrature_lo_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int NUM_PHASES  = 4,
    parameter int DEFAULT_DIV = 0
) (
    input  logic                clk,
    input  logic                n_rst,
    quadrature_lo_gen_if.slave  lo
);
    localparam int              PH_W   = ph_w(NUM_PHASES);
    localparam logic [PH_W-1:0] PH_ONE = PH_W'(1);

    state_t                  state_reg, state_next;
    logic [PH_W-1:0]         p_reg, p_next, p_step;
    logic                    dir_act_reg, dir_act_next;
    logic                    dir_pend_reg, dir_pend_next;
    logic [NUM_PHASES-1:0]   out_ph_reg, out_ph_next;
    logic                    lo_sync_reg, lo_sync_next;
    logic                    running, tick, apply, cfg_pending;

    assign running = (state_reg != IDLE);

    lo_prescaler #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_prescaler (
        .clk         (clk),
        .n_rst       (n_rst),
        .running     (running),
        .cfg_load    (lo.cfg_load),
        .div_ratio   (lo.div_ratio),
        .tick        (tick),
        .apply       (apply),
        .cfg_pending (cfg_pending)
    );

    always_comb begin
        state_next = state_reg;
        p_step     = dir_act_reg ? (p_reg - PH_ONE) : (p_reg + PH_ONE);
        p_next     = p_reg;
        case (state_reg)
            IDLE: begin
                if (lo.en) begin
                    state_next = RUN;
                    p_next     = '0;
                end
            end
            RUN: begin
                if (tick)
                    p_next = p_step;
                if (!lo.en)
                    state_next = STOP;
            end
            STOP: begin
                if (tick)
                    p_next = p_step;
                // Stop only on the wrap so the last phase cycle is never cut short.
                if (lo.en)
                    state_next = RUN;
                else if (tick && (p_next == '0))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        dir_pend_next = lo.cfg_load ? lo.dir : dir_pend_reg;
        dir_act_next  = dir_act_reg;
        if (!running && lo.cfg_load)
            dir_act_next = lo.dir;
        else if (apply)
            dir_act_next = dir_pend_reg;

        lo_sync_next = (state_next == RUN) && (p_next == '0) && ((state_reg == IDLE) || tick);
    end

    // Outputs are decoded from next-state values so the flops track p with no combinational glitches.
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_decode
        assign out_ph_next[gi] = (state_next != IDLE) && phase_bit(int'(p_next), gi, NUM_PHASES);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= IDLE;
            p_reg        <= '0;
            dir_act_reg  <= 1'b0;
            dir_pend_reg <= 1'b0;
            out_ph_reg   <= '0;
            lo_sync_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            p_reg        <= p_next;
            dir_act_reg  <= dir_act_next;
            dir_pend_reg <= dir_pend_next;
            out_ph_reg   <= out_ph_next;
            lo_sync_reg  <= lo_sync_next;
        end
    end

    assign lo.out_ph      = out_ph_reg;
    assign lo.lo_sync     = lo_sync_reg;
    assign lo.busy        = running;
    assign lo.cfg_pending = cfg_pending;

endmodule
